time_counter_gen: RTL

TIME_COUNTER_GEN -- requirements
Module: time_counter_gen

---
 rtl/time_pkg.sv | 25 ++
 rtl/mod_counter.sv | 39 +++
 rtl/time_counter_gen.sv | 104 ++++++++++
 3 files changed

// File: rtl/time_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | time_pkg                                                             |
// | Field widths, CTI/CTO bit positions and moduli for the time counter. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package time_pkg;

    localparam int c_ONES_W = 4;
    localparam int c_TENS_W = 3;
    localparam int c_HOUR_W = 5;
    localparam int c_DAY_W  = 3;
    localparam int c_CT_W   = c_ONES_W + c_TENS_W + c_HOUR_W + c_DAY_W;

    localparam int c_ONES_LSB = 0;
    localparam int c_TENS_LSB = c_ONES_LSB + c_ONES_W;
    localparam int c_HOUR_LSB = c_TENS_LSB + c_TENS_W;
    localparam int c_DAY_LSB  = c_HOUR_LSB + c_HOUR_W;

    localparam int c_ONES_MOD = 10;
    localparam int c_TENS_MOD = 6;
    localparam int c_HOUR_MOD = 24;

endpackage : time_pkg
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mod_counter                                                          |
// | Modulo-N counter with clear, load and ripple carry-in/carry-out.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             carry_in,
    output logic             carry_out,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;

    assign carry_out = carry_in && (r_count == c_MAX);
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (carry_in) begin
            r_count <= (r_count == c_MAX) ? '0 : r_count + WIDTH'(1);
        end
    end

endmodule : mod_counter
`default_nettype wire

// File: rtl/time_counter_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | time_counter_gen                                                     |
// | Minute prescaler driving a BCD-minute / hour / day-of-week counter.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module time_counter_gen
    import time_pkg::*;
#(
    parameter int TICKS_PER_MIN = 60000,
    parameter int DAYS_PER_WEEK = 7
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              EN_CT,
    input  logic              Clr_CT,
    input  logic              LD_CT,
    input  logic [c_CT_W-1:0] CTI,
    output logic [c_CT_W-1:0] CTO,
    output logic              Tick_Min,
    output logic              Day_Wrap,
    output logic              Load_Err
);

    localparam int c_PS_W_RAW = $clog2(TICKS_PER_MIN + 1);
    localparam int c_PS_W     = (c_PS_W_RAW < 1) ? 1 : c_PS_W_RAW;
    localparam logic [c_PS_W-1:0] c_PS_MAX = c_PS_W'(TICKS_PER_MIN - 1);
    localparam logic [c_DAY_W:0]  c_DPW    = (c_DAY_W + 1)'(DAYS_PER_WEEK);

    logic [c_PS_W-1:0]   r_ps;
    logic                r_tick;
    logic                r_day_wrap;
    logic                r_load_err;

    logic [c_ONES_W-1:0] w_ones_in, w_ones;
    logic [c_TENS_W-1:0] w_tens_in, w_tens;
    logic [c_HOUR_W-1:0] w_hour_in, w_hour;
    logic [c_DAY_W-1:0]  w_day_in,  w_day;
    logic                w_valid;
    logic                w_load_ok;
    logic                w_advance;
    logic                w_ones_c, w_tens_c, w_hour_c, w_day_c;

    assign w_ones_in = CTI[c_ONES_LSB +: c_ONES_W];
    assign w_tens_in = CTI[c_TENS_LSB +: c_TENS_W];
    assign w_hour_in = CTI[c_HOUR_LSB +: c_HOUR_W];
    assign w_day_in  = CTI[c_DAY_LSB  +: c_DAY_W];

    assign w_valid = (w_ones_in <= c_ONES_W'(c_ONES_MOD - 1))
                  && (w_tens_in <= c_TENS_W'(c_TENS_MOD - 1))
                  && (w_hour_in <= c_HOUR_W'(c_HOUR_MOD - 1))
                  && ({1'b0, w_day_in} < c_DPW);

    // Clear outranks load, so a load coinciding with a clear is simply dropped.
    assign w_load_ok = LD_CT && w_valid && !Clr_CT;
    assign w_advance = EN_CT && (r_ps == c_PS_MAX);

    always_ff @(posedge Clk) begin
        if (Rst || Clr_CT || w_load_ok) begin
            r_ps <= '0;
        end else if (EN_CT) begin
            r_ps <= (r_ps == c_PS_MAX) ? '0 : r_ps + c_PS_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_tick     <= 1'b0;
            r_day_wrap <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_tick     <= w_advance && !Clr_CT && !w_load_ok;
            r_day_wrap <= w_day_c && !Clr_CT && !w_load_ok;
            r_load_err <= LD_CT && !w_valid && !Clr_CT;
        end
    end

    mod_counter #(.WIDTH(c_ONES_W), .MODULUS(c_ONES_MOD)) u_ones (
        .clk(Clk), .rst(Rst), .clr(Clr_CT), .load(w_load_ok), .load_val(w_ones_in),
        .carry_in(w_advance), .carry_out(w_ones_c), .count(w_ones)
    );

    mod_counter #(.WIDTH(c_TENS_W), .MODULUS(c_TENS_MOD)) u_tens (
        .clk(Clk), .rst(Rst), .clr(Clr_CT), .load(w_load_ok), .load_val(w_tens_in),
        .carry_in(w_ones_c), .carry_out(w_tens_c), .count(w_tens)
    );

    mod_counter #(.WIDTH(c_HOUR_W), .MODULUS(c_HOUR_MOD)) u_hour (
        .clk(Clk), .rst(Rst), .clr(Clr_CT), .load(w_load_ok), .load_val(w_hour_in),
        .carry_in(w_tens_c), .carry_out(w_hour_c), .count(w_hour)
    );

    mod_counter #(.WIDTH(c_DAY_W), .MODULUS(DAYS_PER_WEEK)) u_day (
        .clk(Clk), .rst(Rst), .clr(Clr_CT), .load(w_load_ok), .load_val(w_day_in),
        .carry_in(w_hour_c), .carry_out(w_day_c), .count(w_day)
    );

    assign CTO      = {w_day, w_hour, w_tens, w_ones};
    assign Tick_Min = r_tick;
    assign Day_Wrap = r_day_wrap;
    assign Load_Err = r_load_err;

endmodule : time_counter_gen
`default_nettype wire
